pwm_cmd_decoder: RTL and testbench

//  Receive side of the servo-style PWM command link: measures the high time of an

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/pwm_width_classify.sv | 38 +++
 rtl/pwm_cmd_decoder.sv | 171 +++++++++++++++++
 tb/tb_pwm_cmd_decoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: types and constants shared between the PWM command decoder and the
// motor driver that consumes its output.
//   instr_t      2-bit motor command (01 forward, 10 back, 11 stop)
//   dec_state_t  decoder FSM state, visible as the "state" signal in the top
//   PWM_PERIOD   nominal frame length in ticks
//   NOM_*_W      nominal pulse widths for each command
package pwm_pkg;

  typedef enum logic [1:0] {
    INSTR_FWD  = 2'b01,
    INSTR_BACK = 2'b10,
    INSTR_STOP = 2'b11
  } instr_t;

  typedef enum logic [1:0] {
    ST_ARM    = 2'b00,
    ST_IDLE   = 2'b01,
    ST_HIGH   = 2'b10,
    ST_DECODE = 2'b11
  } dec_state_t;

  localparam int PWM_PERIOD = 3072;
  localparam int NOM_BACK_W = 154;
  localparam int NOM_STOP_W = 230;
  localparam int NOM_FWD_W  = 307;

endpackage

// File: rtl/pwm_width_classify.sv
// pwm_width_classify: purely combinational mapping of a measured pulse width
// onto a motor command.
//   width  in   CNT_W  measured high time in clk ticks
//   code   out  2      INSTR_BACK / INSTR_STOP / INSTR_FWD (STOP when illegal)
//   legal  out  1      width lies inside MIN_WIDTH..MAX_WIDTH
// Widths between BACK_MAX and FWD_MIN form the STOP dead band.
module pwm_width_classify
  import pwm_pkg::*;
#(
  parameter int CNT_W     = 14,
  parameter int MIN_WIDTH = 100,
  parameter int BACK_MAX  = 192,
  parameter int FWD_MIN   = 268,
  parameter int MAX_WIDTH = 400
) (
  input  logic [CNT_W-1:0] width,
  output logic [1:0]       code,
  output logic             legal
);

  localparam logic [CNT_W-1:0] MIN_W  = CNT_W'(MIN_WIDTH);
  localparam logic [CNT_W-1:0] BACK_W = CNT_W'(BACK_MAX);
  localparam logic [CNT_W-1:0] FWD_W  = CNT_W'(FWD_MIN);
  localparam logic [CNT_W-1:0] MAX_W  = CNT_W'(MAX_WIDTH);

  always_comb begin
    code  = INSTR_STOP;
    legal = 1'b1;
    if ((width < MIN_W) || (width > MAX_W)) begin
      legal = 1'b0;
    end else if (width <= BACK_W) begin
      code = INSTR_BACK;
    end else if (width >= FWD_W) begin
      code = INSTR_FWD;
    end
  end

endmodule

// File: rtl/pwm_cmd_decoder.sv
// pwm_cmd_decoder: receive side of the servo-style PWM command link. Measures
// the high time of each pulse on pwm_in and turns it into a 2-bit motor
// command, falling back to STOP when the link goes quiet.
//   clk      in   1  system clock, all logic on posedge
//   reset    in   1  synchronous active-high reset
//   pwm_in   in   1  asynchronous PWM input, high = pulse
//   instr    out  2  decoded command (pwm_pkg::instr_t), registered
//   valid    out  1  1-cycle strobe: instr was just updated from a legal frame
//   err      out  1  1-cycle strobe: last pulse width outside MIN..MAX
//   timeout  out  1  level: no rising edge for TIMEOUT_TICKS, instr forced STOP
// Handshake: valid and err are single-cycle strobes with no ready/backpressure;
// the consumer must take instr in the cycle valid is high (instr also holds
// its value afterwards). They are never high together and only during DECODE.
// Optional build macro PWM_DEC_CONFIRM_EN: a legal code only reaches instr when
// it matches the previous legal frame's code (2-frame confirmation).
module pwm_cmd_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W         = 14,
  parameter int MIN_WIDTH     = 100,
  parameter int BACK_MAX      = 192,
  parameter int FWD_MIN       = 268,
  parameter int MAX_WIDTH     = 400,
  parameter int TIMEOUT_TICKS = 9216
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [1:0] instr,
  output logic       valid,
  output logic       err,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] WIDTH_SAT = CNT_W'(MAX_WIDTH + 1);
  localparam logic [CNT_W-1:0] TO_SAT    = CNT_W'(TIMEOUT_TICKS);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_TICKS - 1);

  logic             s_meta;
  logic             s;
  logic             s_q;
  logic             rise;
  logic             fall;
  logic             to_hit;
  dec_state_t       state;
  logic [CNT_W-1:0] width;
  logic [CNT_W-1:0] to_cnt;
  logic [1:0]       code;
  logic             legal;
`ifdef PWM_DEC_CONFIRM_EN
  logic [1:0]       prev_code;
  logic             prev_ok;
`endif

  pwm_width_classify #(
    .CNT_W     (CNT_W),
    .MIN_WIDTH (MIN_WIDTH),
    .BACK_MAX  (BACK_MAX),
    .FWD_MIN   (FWD_MIN),
    .MAX_WIDTH (MAX_WIDTH)
  ) u_classify (
    .width (width),
    .code  (code),
    .legal (legal)
  );

  assign rise   = s & ~s_q;
  assign fall   = ~s & s_q;
  // A rise in the same cycle clears the counter, so it beats the timeout.
  assign to_hit = ~rise & (to_cnt == TO_LAST);

  // The synchronizer resets to all-ones: a pulse already in progress when
  // reset releases then never shows up as a rising edge, and a low input
  // only produces a fall, which ARM ignores.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
      s_q    <= 1'b1;
    end else begin
      s_meta <= pwm_in;
      s      <= s_meta;
      s_q    <= s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_ARM;
      width   <= '0;
      to_cnt  <= '0;
      instr   <= INSTR_STOP;
      valid   <= 1'b0;
      err     <= 1'b0;
      timeout <= 1'b0;
`ifdef PWM_DEC_CONFIRM_EN
      prev_code <= INSTR_STOP;
      prev_ok   <= 1'b0;
`endif
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;

      case (state)
        ST_ARM: begin
          if (!s) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (rise) begin
            state <= ST_HIGH;
            width <= CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (fall) begin
            // Outputs are registered on the transition so that the strobe is
            // visible while the FSM sits in DECODE, one cycle after the fall.
            state <= ST_DECODE;
            if (!legal) begin
              err <= 1'b1;
`ifdef PWM_DEC_CONFIRM_EN
              prev_ok <= 1'b0;
`endif
            end else begin
              timeout <= 1'b0;
`ifdef PWM_DEC_CONFIRM_EN
              prev_code <= code;
              prev_ok   <= 1'b1;
              if (prev_ok && (code == prev_code)) begin
                instr <= code;
                valid <= 1'b1;
              end
`else
              instr <= code;
              valid <= 1'b1;
`endif
            end
          end else if (s && (width != WIDTH_SAT)) begin
            width <= width + 1'b1;
          end
        end
        ST_DECODE: begin
          // A one-cycle low gap must not swallow the next pulse.
          if (rise) begin
            state <= ST_HIGH;
            width <= CNT_W'(1);
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_ARM;
      endcase

      if (rise) begin
        to_cnt <= '0;
      end else if (to_cnt != TO_SAT) begin
        to_cnt <= to_cnt + 1'b1;
      end

      // Fail safe: placed last so it overrides a decode in the same cycle.
      if (to_hit) begin
        timeout <= 1'b1;
        instr   <= INSTR_STOP;
`ifdef PWM_DEC_CONFIRM_EN
        prev_ok <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_pwm_cmd_decoder.sv
// Bench for pwm_cmd_decoder: directed frames with literal expectations plus a
// per-cycle comparison against a behavioural model of the decoder.
module tb_pwm_cmd_decoder;

  localparam int T_OUT = 9216;

  logic       clk;
  logic       reset;
  logic       pwm_in;
  logic [1:0] instr;
  logic       valid;
  logic       err;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  pwm_cmd_decoder dut (
    .clk     (clk),
    .reset   (reset),
    .pwm_in  (pwm_in),
    .instr   (instr),
    .valid   (valid),
    .err     (err),
    .timeout (timeout)
  );

  // ---------------------------------------------------------------- clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------------------------------------------------------- model
  // The decoder sees pwm_in through two flops; the model keeps that two-edge
  // view (p_m1/p_m2) and applies the width/timeout rules to it directly.
  logic [1:0] m_instr   = 2'b11;
  logic       m_valid   = 1'b0;
  logic       m_err     = 1'b0;
  logic       m_timeout = 1'b0;
  logic       p_m1 = 1'b1, p_m2 = 1'b1, d_prev = 1'b1;
  logic       armed = 1'b0, in_pulse = 1'b0;
  int         run = 0;
  int         since = 0;
  logic [1:0] prev_c = 2'b11;
  logic       prev_ok = 1'b0;

  always @(posedge clk) begin : model
    logic       d;
    logic [1:0] c;
    if (reset) begin
      m_instr = 2'b11; m_valid = 1'b0; m_err = 1'b0; m_timeout = 1'b0;
      p_m1 = 1'b1; p_m2 = 1'b1; d_prev = 1'b1;
      armed = 1'b0; in_pulse = 1'b0; run = 0; since = 0; prev_ok = 1'b0;
    end else begin
      d = p_m2;
      p_m2 = p_m1;
      p_m1 = pwm_in;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (!armed) begin
        if (!d) armed = 1'b1;
      end else if (d && !d_prev) begin
        in_pulse = 1'b1;
        run = 1;
      end else if (in_pulse && d) begin
        run++;
      end else if (in_pulse && !d) begin
        in_pulse = 1'b0;
        if (run < 100 || run > 400) begin
          m_err = 1'b1;
          prev_ok = 1'b0;
        end else begin
          if (run <= 192) c = 2'b10;
          else if (run >= 268) c = 2'b01;
          else c = 2'b11;
          m_timeout = 1'b0;
`ifdef PWM_DEC_CONFIRM_EN
          if (prev_ok && c == prev_c) begin
            m_instr = c;
            m_valid = 1'b1;
          end
          prev_c = c;
          prev_ok = 1'b1;
`else
          m_instr = c;
          m_valid = 1'b1;
`endif
        end
      end
      if (d && !d_prev) begin
        since = 0;
      end else if (since < T_OUT) begin
        since++;
        if (since == T_OUT) begin
          m_timeout = 1'b1;
          m_instr = 2'b11;
          prev_ok = 1'b0;
        end
      end
      d_prev = d;
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    checks++;
    if ({instr, valid, err, timeout} !== {m_instr, m_valid, m_err, m_timeout}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t got instr=%b valid=%b err=%b timeout=%b want instr=%b valid=%b err=%b timeout=%b",
               $time, instr, valid, err, timeout, m_instr, m_valid, m_err, m_timeout);
    end
  end

  // ---------------------------------------------------------------- driver tasks
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_instr"}, instr, 2'b11);
    chk({tag, "_valid"}, valid, 1'b0);
    chk({tag, "_err"}, err, 1'b0);
    chk({tag, "_timeout"}, timeout, 1'b0);
  endtask

  // kind 0: legal frame updating instr to want_code; 1: error strobe with
  // instr held at want_code; 2: no strobe, instr stays want_code.
  task automatic frame(input int hi, input int lo, input int kind,
                       input logic [1:0] want_code, input string tag);
    pwm_in = 1'b1;
    repeat (hi) @(posedge clk);
    #1 pwm_in = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      if (k < 3) begin
        chk({tag, "_early_valid"}, valid, 1'b0);
        chk({tag, "_early_err"}, err, 1'b0);
      end
    end
    chk({tag, "_valid"}, valid, (kind == 0) ? 1'b1 : 1'b0);
    chk({tag, "_err"}, err, (kind == 1) ? 1'b1 : 1'b0);
    chk({tag, "_instr"}, instr, want_code);
    idle(lo - 3);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #800000;
    errors++;
    $display("FAIL watchdog t=%0t sequence did not complete", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- sequence
  initial begin
    reset  = 1'b1;
    pwm_in = 1'b0;
    idle(3);
    chk_reset_vals("reset");
    reset = 1'b0;
    idle(10);

`ifdef PWM_DEC_CONFIRM_EN
    frame(307, 3072 - 307, 2, 2'b11, "c_fwd1");
    frame(154, 3072 - 154, 2, 2'b11, "c_back1");
    frame(154, 3072 - 154, 0, 2'b10, "c_back2");
    frame(154, 300, 0, 2'b10, "c_back3");
    frame(99, 300, 1, 2'b10, "c_err");
    frame(307, 500, 2, 2'b10, "c_fwd2");
    frame(307, 500, 0, 2'b01, "c_fwd3");
`else
    // nominal frames
    frame(154, 3072 - 154, 0, 2'b10, "t1_back");
    frame(230, 3072 - 230, 0, 2'b11, "t1_stop");
    frame(307, 3072 - 307, 0, 2'b01, "t1_fwd");

    // classification boundaries
    frame(99, 150, 1, 2'b01, "t2_w99");
    frame(100, 150, 0, 2'b10, "t2_w100");
    frame(192, 150, 0, 2'b10, "t2_w192");
    frame(193, 150, 0, 2'b11, "t2_w193");
    frame(267, 150, 0, 2'b11, "t2_w267");
    frame(268, 150, 0, 2'b01, "t2_w268");
    frame(400, 150, 0, 2'b01, "t2_w400");
    frame(401, 150, 1, 2'b01, "t2_w401");
    frame(600, 150, 1, 2'b01, "t2_w600");

    // timeout: fires exactly TIMEOUT_TICKS edges after the synced rise
    frame(307, 3072 - 307, 0, 2'b01, "t3_pre");
    chk("t3_no_timeout_yet", timeout, 1'b0);
    idle(T_OUT + 2 - 3072);
    chk("t3_timeout_edge_minus1", timeout, 1'b0);
    idle(1);
    chk("t3_timeout_set", timeout, 1'b1);
    chk("t3_timeout_instr", instr, 2'b11);
    idle(100);
    chk("t3_timeout_held", timeout, 1'b1);
    frame(307, 3072 - 307, 0, 2'b01, "t3_recover");
    chk("t3_timeout_clear", timeout, 1'b0);

    // input already high when reset releases
    pwm_in = 1'b1;
    reset  = 1'b1;
    idle(3);
    chk_reset_vals("t4_reset");
    reset = 1'b0;
    idle(200);
    pwm_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      chk("t4_partial_valid", valid, 1'b0);
      chk("t4_partial_err", err, 1'b0);
    end
    chk("t4_partial_instr", instr, 2'b11);
    idle(50);
    frame(154, 3072 - 154, 0, 2'b10, "t4_next");

    // reset in the middle of a 307 pulse
    pwm_in = 1'b1;
    idle(150);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    chk_reset_vals("t5_reset");
    idle(157);
    pwm_in = 1'b0;
    for (int k = 0; k < 10; k++) begin
      idle(1);
      chk("t5_cut_valid", valid, 1'b0);
      chk("t5_cut_err", err, 1'b0);
    end
    chk("t5_cut_instr", instr, 2'b11);
    idle(50);
    frame(307, 3072 - 307, 0, 2'b01, "t5_next");
`endif

    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
